ram_dma_initiator: RTL and testbench
====================================

Name: ram_dma_initiator

Overview:
- Bus initiator for the 256-word data RAM. It runs block FILL and block COPY operations by driving the RAM's address, write-enable and write-data inputs, and consumes its registered read-data output.
- Sits beside the CPU on the RAM port, behind a port mux owned by the top level. Typical uses are clearing memory and moving buffers without CPU instruction overhead.
- Accepts one command at a time through a start/ready handshake. Reports completion with a one-cycle done pulse, or rejects an illegal command with an error pulse.

Parameters:
- DATA_W, 16, RAM word width
- ADDR_W, 16, RAM address bus width
- DEPTH, 256, number of valid RAM words; legal addresses are 0..DEPTH-1
- LEN_W, 9, width of the length field; must hold the value DEPTH

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  command strobe; sampled only while ready=1
- op  input  1  0=FILL, 1=COPY
- src_addr  input  ADDR_W  COPY source base address; ignored for FILL
- dst_addr  input  ADDR_W  destination base address
- len  input  LEN_W  number of words to process, 0..DEPTH
- fill_value  input  DATA_W  word written by FILL
- ready  output  1  high in IDLE; a command may be accepted
- done  output  1  one-cycle pulse when a command completes
- err  output  1  one-cycle pulse when a command is rejected
- mem_addr  output  ADDR_W  to RAM addr
- mem_wdata  output  DATA_W  to RAM data_in
- mem_we  output  1  to RAM we_M
- mem_rdata  input  DATA_W  from RAM data_out; valid the cycle after its address was presented

Behaviour:
- Reset (reset=0, takes effect immediately, no clock needed):
  - FSM goes to IDLE; counter cleared.
  - ready=1; done=0; err=0; mem_we=0; mem_addr=0; mem_wdata=0.
  - Reset mid-command abandons the command. Writes already performed remain; no further writes occur.
- States: IDLE, CHECK, FILL_WR, COPY_RD, COPY_WR, DONE, ERR.
- Accept: on a clock edge with ready=1 and start=1:
  - latch op, src_addr, dst_addr, len, fill_value; clear the word counter i; go to CHECK.
  - start is ignored in every other state.
- CHECK (1 cycle, no memory access):
  - Go to ERR if dst+len > DEPTH.
  - For COPY, also go to ERR if src+len > DEPTH.
  - For COPY, also go to ERR on overlap with dst > src and dst < src+len (a forward copy would corrupt the source).
  - All sums are computed at ADDR_W+1 bits, so no wrap-around is possible.
  - Else if len=0, go to DONE.
  - Else go to FILL_WR (op=0) or COPY_RD (op=1).
- FILL_WR:
  - Each cycle: mem_addr=dst+i, mem_wdata=fill_value, mem_we=1, then i++.
  - After the write with i=len-1, go to DONE.
  - Throughput is 1 word/cycle.
- COPY_RD: mem_addr=src+i, mem_we=0; go to COPY_WR.
- COPY_WR:
  - mem_addr=dst+i, mem_wdata=mem_rdata (the word captured by RAM at the COPY_RD edge), mem_we=1, then i++.
  - If i=len-1, go to DONE; else go to COPY_RD.
  - Throughput is 2 cycles/word.
- mem_we is 1 only in FILL_WR and COPY_WR. In all other states mem_we=0 and mem_addr holds its last value.
- DONE: done=1 for exactly one cycle, then IDLE.
- ERR: err=1 for exactly one cycle, then IDLE. No write is ever issued for a rejected command.
- done and err are never high together; ready=0 in every state except IDLE.
- Latency, with the accept edge as edge 0:
  - FILL of N words: writes in cycles 2..N+1; done in cycle N+2.
  - COPY of N words: done in cycle 2N+2.
  - len=0 or error: done or err in cycle 2.
- len=DEPTH with base address 0 is legal and covers the whole RAM.

Test Plan:
- FILL: dst=0x10, len=4, fill_value=0xBEEF -> mem_we high exactly 4 cycles at addr 0x10..0x13; RAM[0x10..0x13]=0xBEEF; RAM[0x0F] and RAM[0x14] unchanged; done pulses once, 6 cycles after accept.
- COPY: preload RAM[0x20..0x22]=1,2,3; src=0x20, dst=0x80, len=3 -> RAM[0x80..0x82]=1,2,3; alternating read/write addresses 0x20,0x80,0x21,0x81,0x22,0x82; done 8 cycles after accept.
- Range and overlap errors: FILL dst=0xFE len=3 -> err pulse, no mem_we. COPY src=0x10 dst=0x12 len=4 -> err pulse. COPY src=0x12 dst=0x10 len=4 -> legal, done, correct data.
- Boundaries: FILL dst=0 len=256 -> all 256 words written, last at addr 0xFF, done. len=0 -> done with zero writes.
- Handshake: start held high during a busy command -> ignored, ready=0 throughout; a new command is accepted only the cycle after done.
- Reset mid-FILL: len=8, reset=0 after 3 writes -> mem_we=0 immediately, ready=1, only 3 words modified, no done pulse.

Source files
------------

// File: rtl/ram_dma_initiator_if.sv
// Command and RAM-port bundle for the block FILL/COPY initiator.
// The master side issues commands and owns the RAM; the slave side is the initiator.
interface ram_dma_initiator_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 9
) ();
    logic              start;
    logic              op;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] fill_value;
    logic              ready;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output start, op, src_addr, dst_addr, len, fill_value, mem_rdata,
        input  ready, done, err, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  start, op, src_addr, dst_addr, len, fill_value, mem_rdata,
        output ready, done, err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/ram_dma_initiator.sv
// Block FILL / COPY engine driving the data RAM port; one command at a time,
// range-checked before any write, completion or rejection reported by one-cycle pulses.
module ram_dma_initiator #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int LEN_W  = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_dma_initiator_if.slave    bus
);
    localparam int SUM_W = ADDR_W + 1;
    typedef logic [SUM_W-1:0] sum_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FILL_WR,
        S_COPY_RD,
        S_COPY_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  i_q, i_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    sum_t              dst_end_s;
    sum_t              src_end_s;
    logic              range_err_s;
    logic              last_word_s;

    // Range/overlap legality of the latched command; one extra bit so nothing wraps.
    always_comb begin
        dst_end_s   = sum_t'(dst_q) + sum_t'(len_q);
        src_end_s   = sum_t'(src_q) + sum_t'(len_q);
        range_err_s = (dst_end_s > sum_t'(DEPTH)) ||
                      (op_q && ((src_end_s > sum_t'(DEPTH)) ||
                                ((dst_q > src_q) && (sum_t'(dst_q) < src_end_s))));
        last_word_s = (i_q == (len_q - LEN_W'(1)));
    end

    // Next state, command latch and word counter.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        i_d     = i_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    src_d   = bus.src_addr;
                    dst_d   = bus.dst_addr;
                    len_d   = bus.len;
                    fill_d  = bus.fill_value;
                    i_d     = '0;
                    state_d = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (range_err_s) begin
                    state_d = S_ERR;
                end else if (len_q == '0) begin
                    state_d = S_DONE;
                end else if (op_q) begin
                    state_d = S_COPY_RD;
                end else begin
                    state_d = S_FILL_WR;
                end
            end
            S_FILL_WR: begin
                if (last_word_s) begin
                    state_d = S_DONE;
                end else begin
                    i_d = i_q + LEN_W'(1);
                end
            end
            S_COPY_RD: state_d = S_COPY_WR;
            S_COPY_WR: begin
                if (last_word_s) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + LEN_W'(1);
                    state_d = S_COPY_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        ready_d  = (state_d == S_IDLE);
        done_d   = (state_d == S_DONE);
        err_d    = (state_d == S_ERR);
        mem_we_d = (state_d == S_FILL_WR) || (state_d == S_COPY_WR);
        case (state_d)
            S_FILL_WR, S_COPY_WR: mem_addr_d = dst_q + ADDR_W'(i_d);
            S_COPY_RD:            mem_addr_d = src_q + ADDR_W'(i_d);
            default:              mem_addr_d = mem_addr_q;
        endcase
        // The copied word is only known during COPY_WR; keep it afterwards so wdata holds.
        if (state_d == S_FILL_WR) begin
            mem_wdata_d = fill_q;
        end else if (state_q == S_COPY_WR) begin
            mem_wdata_d = bus.mem_rdata;
        end else begin
            mem_wdata_d = mem_wdata_q;
        end
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            fill_q      <= '0;
            i_q         <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            fill_q      <= fill_d;
            i_q         <= i_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // RAM read data arrives registered, so the copy write passes it straight through.
    assign bus.mem_wdata = (state_q == S_COPY_WR) ? bus.mem_rdata : mem_wdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_ram_dma_initiator.sv
// Bench for ram_dma_initiator: behavioural RAM plus an array reference model,
// directed corner commands followed by randomized commands.
module tb_ram_dma_initiator;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;
    localparam int LEN_W  = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_dma_initiator_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    ram_dma_initiator #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Behavioural RAM with registered read port and a bench back-door write port.
    logic [DATA_W-1:0] ram [DEPTH];
    logic              tb_we = 1'b0;
    logic [7:0]        tb_addr = 8'd0;
    logic [DATA_W-1:0] tb_data = '0;
    int                oob_writes = 0;
    always @(posedge clk) begin
        if (tb_we) begin
            ram[tb_addr] <= tb_data;
        end else if (bus.mem_we) begin
            if (bus.mem_addr < ADDR_W'(DEPTH)) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else oob_writes <= oob_writes + 1;
        end
        bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end

    logic [DATA_W-1:0] ref_mem [DEPTH];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_ram(input string name);
        int bad = 0;
        for (int a = 0; a < DEPTH; a++) if (ram[a] !== ref_mem[a]) bad++;
        check({name, "/ram_words_wrong"}, bad, 0);
    endtask

    task automatic backdoor(input int a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = 8'(a); tb_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic issue(input bit op, input int src, input int dst, input int len,
                         input logic [DATA_W-1:0] fv, input bit hold);
        @(negedge clk);
        check("ready_before_accept", bus.ready, 1);
        bus.op = op; bus.src_addr = ADDR_W'(src); bus.dst_addr = ADDR_W'(dst);
        bus.len = LEN_W'(len); bus.fill_value = fv; bus.start = 1'b1;
        @(posedge clk);
        if (!hold) begin
            #1 bus.start = 1'b0;
        end
    endtask

    // Follows one command from its accept edge; cycle k is the period ending at edge k.
    task automatic observe(input bit op, input int src, input int dst, input int len,
                           input logic [DATA_W-1:0] fv, input string name);
        bit exp_err;
        int exp_p, p, writes, ready_hi, addr_bad, we_bad, k, exp_addr;
        bit exp_we;
        exp_err = (dst + len > DEPTH) ||
                  (op && ((src + len > DEPTH) || (dst > src && dst < src + len)));
        exp_p = (exp_err || len == 0) ? 2 : (op ? 2 * len + 2 : len + 2);
        p = 0; writes = 0; ready_hi = 0; addr_bad = 0; we_bad = 0;
        for (int cyc = 1; cyc <= 2 * DEPTH + 8 && p == 0; cyc++) begin
            @(negedge clk);
            if (bus.ready) ready_hi++;
            if (bus.mem_we) writes++;
            if (bus.done || bus.err) begin
                p = cyc;
                check({name, "/pulse_done_err"}, {bus.done, bus.err}, exp_err ? 2'b01 : 2'b10);
            end else if (cyc >= 2) begin
                k = cyc - 2;
                if (op) begin
                    exp_addr = (k % 2 == 0) ? src + k / 2 : dst + k / 2;
                    exp_we   = (k % 2 == 1);
                end else begin
                    exp_addr = dst + k;
                    exp_we   = 1'b1;
                end
                if (int'(bus.mem_addr) != exp_addr) addr_bad++;
                if (bus.mem_we !== exp_we) we_bad++;
            end
        end
        check({name, "/latency"}, p, exp_p);
        check({name, "/write_cycles"}, writes, (exp_err || len == 0) ? 0 : len);
        check({name, "/ready_while_busy"}, ready_hi, 0);
        check({name, "/addr_sequence"}, addr_bad, 0);
        check({name, "/we_pattern"}, we_bad, 0);
        @(negedge clk);
        check({name, "/after_pulse_rdy_done_err"}, {bus.ready, bus.done, bus.err}, 3'b100);
        if (!exp_err) begin
            for (int j = 0; j < len; j++) ref_mem[dst + j] = op ? ref_mem[src + j] : fv;
        end
        compare_ram(name);
    endtask

    task automatic run(input bit op, input int src, input int dst, input int len,
                       input logic [DATA_W-1:0] fv, input string name);
        issue(op, src, dst, len, fv, 1'b0);
        observe(op, src, dst, len, fv, name);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, src, dst, len, pulses;
        logic [DATA_W-1:0] fv;
        bus.start = 1'b0; bus.op = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
        bus.len = '0; bus.fill_value = '0;
        #2 reset = 1'b0;
        #1;
        check("reset/ready", bus.ready, 1);
        check("reset/done_err_we", {bus.done, bus.err, bus.mem_we}, 3'b000);
        check("reset/mem_addr", bus.mem_addr, 0);
        check("reset/mem_wdata", bus.mem_wdata, 0);
        for (int a = 0; a < DEPTH; a++) backdoor(a, DATA_W'($urandom));
        @(negedge clk) reset = 1'b1;
        compare_ram("init");

        run(1'b0, 0, 'h10, 4, 16'hBEEF, "fill_basic");
        backdoor('h20, 16'd1); backdoor('h21, 16'd2); backdoor('h22, 16'd3);
        run(1'b1, 'h20, 'h80, 3, 16'h0, "copy_basic");
        check("copy_basic/ram80", ram['h80], 1);
        check("copy_basic/ram82", ram['h82], 3);
        run(1'b0, 0, 'hFE, 3, 16'h5A5A, "fill_range_err");
        run(1'b1, 'h10, 'h12, 4, 16'h0, "copy_overlap_err");
        run(1'b1, 'h12, 'h10, 4, 16'h0, "copy_overlap_legal");
        run(1'b1, 'h30, 'h30, 5, 16'h0, "copy_in_place");
        run(1'b1, 'h100, 'h00, 1, 16'h0, "copy_src_range_err");
        run(1'b0, 0, 'hFFFF, 2, 16'h1111, "fill_no_wrap_err");
        run(1'b0, 0, 0, DEPTH, 16'hC0DE, "fill_full_ram");
        run(1'b0, 0, 'h40, 0, 16'hAAAA, "fill_len0");
        run(1'b1, 'h50, 'h60, 0, 16'h0, "copy_len0");
        run(1'b1, 0, 'hFF, 1, 16'h0, "copy_last_word");

        // start held high: ignored while busy, re-accepted only once back in IDLE
        issue(1'b0, 0, 'h70, 3, 16'h7777, 1'b1);
        observe(1'b0, 0, 'h70, 3, 16'h7777, "hold_start_first");
        @(posedge clk);
        observe(1'b0, 0, 'h70, 3, 16'h7777, "hold_start_second");
        bus.start = 1'b0;

        for (int n = 0; n < 24; n++) begin
            op  = int'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH)) : int'($urandom_range(0, 12));
            dst = int'($urandom_range(0, DEPTH - 1));
            src = ($urandom_range(0, 2) == 0) ? dst + int'($urandom_range(0, 6)) - 3 : int'($urandom_range(0, DEPTH - 1));
            if (src < 0) src = 0;
            fv  = DATA_W'($urandom);
            run(op[0], src, dst, len, fv, $sformatf("rand%0d", n));
        end

        // reset after three committed writes of an 8-word fill
        issue(1'b0, 0, 'h40, 8, 16'h1234, 1'b0);
        repeat (4) @(negedge clk);
        @(negedge clk);
        check("midreset/we_before", bus.mem_we, 1);
        reset = 1'b0;
        #1;
        check("midreset/we", bus.mem_we, 0);
        check("midreset/ready", bus.ready, 1);
        check("midreset/addr_wdata", {bus.mem_addr, bus.mem_wdata}, 0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done || bus.err || bus.mem_we) pulses++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.done || bus.err || bus.mem_we) pulses++;
        end
        check("midreset/no_pulse_or_write", pulses, 0);
        for (int j = 0; j < 3; j++) ref_mem['h40 + j] = 16'h1234;
        compare_ram("midreset");
        run(1'b0, 0, 'h44, 2, 16'h4242, "after_reset_fill");

        check("out_of_range_writes", oob_writes, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
